// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one UART transmitter among Nreq byte
//            producers. Define UARTARB_LOCK_EN to keep multi-byte packets
//            contiguous (packet lock driven by LAST).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int Nreq  = 4,
    parameter int Wdata = 8
) (
    input  logic                  CLK,
    input  logic                  NRST,
    input  logic [Nreq-1:0]       REQ,
    input  logic [Nreq-1:0]       LAST,
    input  logic [Nreq*Wdata-1:0] DATA,
    output logic [Nreq-1:0]       ACK,
    output logic [Nreq-1:0]       GNT,
    output logic [Wdata-1:0]      TX_DIN,
    output logic                  TX_OE,
    input  logic                  TX_RDY
);
    localparam int              c_PW      = (Nreq > 1) ? $clog2(Nreq) : 1;
    localparam logic [1:0]      c_S_IDLE  = 2'd0;
    localparam logic [1:0]      c_S_ISSUE = 2'd1;
    localparam logic [1:0]      c_S_BUSY  = 2'd2;
    localparam logic [c_PW-1:0] c_PTR_RST = c_PW'(Nreq - 1);

    logic [1:0]       state_q, state_d;
    logic [c_PW-1:0]  ptr_q, ptr_d;
    logic [Nreq-1:0]  gnt_q, gnt_d;
    logic [Nreq-1:0]  ack_q, ack_d;
    logic [Wdata-1:0] din_q, din_d;
    logic             oe_q, oe_d;

    logic [Nreq-1:0]  w_elig;
    logic [c_PW-1:0]  w_win;
    logic [Nreq-1:0]  w_onehot;
    logic             w_issue;

`ifdef UARTARB_LOCK_EN
    logic lock_q, lock_d;

    // While locked only the owner (last grant) may be served.
    assign w_elig = lock_q ? (REQ & gnt_q) : REQ;

    always_comb begin
        lock_d = lock_q;
        if (w_issue) begin
            lock_d = ~LAST[w_win];
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    // LAST carries no meaning without packet locking.
    assign w_elig = REQ | (LAST & {Nreq{1'b0}});
`endif

    // Smallest eligible index above ptr wins; otherwise smallest at or below it.
    always_comb begin
        w_win = '0;
        for (int j = Nreq - 1; j >= 0; j--) begin
            if (w_elig[j] && (c_PW'(j) <= ptr_q)) begin
                w_win = c_PW'(j);
            end
        end
        for (int j = Nreq - 1; j >= 0; j--) begin
            if (w_elig[j] && (c_PW'(j) > ptr_q)) begin
                w_win = c_PW'(j);
            end
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_win] = 1'b1;
    end

    // The transmitter's ready flag is stale during ISSUE, so never issue there.
    assign w_issue = (state_q != c_S_ISSUE) && TX_RDY && (|w_elig);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        din_d   = din_q;
        ack_d   = '0;
        oe_d    = 1'b0;
        if (w_issue) begin
            state_d = c_S_ISSUE;
            ptr_d   = w_win;
            gnt_d   = w_onehot;
            din_d   = DATA[w_win*Wdata +: Wdata];
            ack_d   = w_onehot;
            oe_d    = 1'b1;
        end else begin
            case (state_q)
                c_S_IDLE:  state_d = c_S_IDLE;
                c_S_ISSUE: state_d = c_S_BUSY;
                c_S_BUSY:  state_d = TX_RDY ? c_S_IDLE : c_S_BUSY;
                default:   state_d = c_S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q <= c_S_IDLE;
            ptr_q   <= c_PTR_RST;
            gnt_q   <= '0;
            ack_q   <= '0;
            din_q   <= '0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            din_q   <= din_d;
            oe_q    <= oe_d;
        end
    end

    assign ACK    = ack_q;
    assign GNT    = gnt_q;
    assign TX_DIN = din_q;
    assign TX_OE  = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter; expectations
//            switch with UARTARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int c_FRAME = 10;

    logic        clk;
    logic        nrst;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [3:0]  gnt;
    logic [7:0]  tx_din;
    logic        tx_oe;
    logic        tx_rdy;

    logic        tx_auto;
    logic        tx_man;
    int          tx_cnt;

    int          n_total;
    int          n_bad;
    int          viol;
    logic        prev_rdy;
    logic        prev_oe;
    int          aq[$];
    logic [7:0]  dq[$];

    uart_tx_arbiter #(.Nreq(4), .Wdata(8)) dut (
        .CLK    (clk),
        .NRST   (nrst),
        .REQ    (req),
        .LAST   (last),
        .DATA   (data),
        .ACK    (ack),
        .GNT    (gnt),
        .TX_DIN (tx_din),
        .TX_OE  (tx_oe),
        .TX_RDY (tx_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy for c_FRAME cycles after sampling OE; not reset by NRST.
    always @(posedge clk) begin
        if (!tx_auto)        tx_cnt <= 0;
        else if (tx_oe)      tx_cnt <= c_FRAME;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    end
    assign tx_rdy = tx_auto ? (tx_cnt == 0) : tx_man;

    function automatic int oh2i(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) begin
            if (v == (4'b0001 << i)) r = i;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (ack != 4'b0000) begin
            aq.push_back(oh2i(ack));
            dq.push_back(tx_din);
        end
        if ((tx_oe && (!prev_rdy || prev_oe)) || (tx_oe != (ack != 4'b0000)) ||
            ((ack != 4'b0000) && (oh2i(ack) < 0)))
            viol <= viol + 1;
        prev_rdy <= tx_rdy;
        prev_oe  <= tx_oe;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
    endtask

    // Bounded wait for the next ACK; a timeout leaves got=0 for the caller's check.
    task automatic wait_ack(input int budget, output logic [3:0] got, output int cyc);
        got = 4'b0000;
        cyc = 0;
        while ((cyc < budget) && (got == 4'b0000)) begin
            step();
            cyc++;
            got = ack;
        end
    endtask

    logic [3:0] a;
    int         cyc;
    int         cnt;
    int         c1;
    int         exp_idx[5];
    logic [7:0] exp_din[5];

    initial begin
        n_total = 0; n_bad = 0; viol = 0;
        prev_rdy = 1'b0; prev_oe = 1'b0;
        tx_auto = 1'b0; tx_man = 1'b1;
        nrst = 1'b0; req = 4'b0000; last = 4'b0000; data = 32'h0;

        // Reset values and first issue latency.
        step(); step();
        check_val("rst_oe",  {31'b0, tx_oe}, 32'd0);
        check_val("rst_ack", {28'b0, ack},   32'd0);
        check_val("rst_gnt", {28'b0, gnt},   32'd0);
        check_val("rst_din", {24'b0, tx_din}, 32'd0);
        nrst = 1'b1; req = 4'b0001; data[7:0] = 8'h55;
        wait_ack(20, a, cyc);
        check_val("t1_ack", {28'b0, a}, 32'h1);
        check_val("t1_lat", cyc, 32'd1);
        check_val("t1_oe",  {31'b0, tx_oe}, 32'd1);
        check_val("t1_din", {24'b0, tx_din}, 32'h55);
        check_val("t1_gnt", {28'b0, gnt}, 32'h1);
        req = 4'b0000;
        step();
        check_val("t1_oe_drop",  {31'b0, tx_oe}, 32'd0);
        check_val("t1_ack_drop", {28'b0, ack},   32'd0);
        check_val("t1_din_hold", {24'b0, tx_din}, 32'h55);

        // Round robin over all four with a real transmitter.
        tx_auto = 1'b1;
        do_reset();
        data = 32'hA3A2A1A0; last = 4'b1111; req = 4'b1111;
        aq.delete(); dq.delete();
        for (int i = 0; i < 600 && aq.size() < 5; i++) step();
        req = 4'b0000;
        check_val("rr_count", {31'b0, aq.size() >= 5}, 32'd1);
        exp_idx = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5 && i < aq.size(); i++) begin
            check_val($sformatf("rr_idx%0d", i), aq[i], exp_idx[i]);
            check_val($sformatf("rr_din%0d", i), {24'b0, dq[i]}, {24'b0, 8'hA0 + 8'(exp_idx[i])});
        end
        for (int i = 0; i < 30; i++) step();

        // Three-byte packet from requester 1 against a persistent requester 2.
        do_reset();
        data = 32'h0; data[15:8] = 8'h10; data[23:16] = 8'h20;
        last = 4'b0100; req = 4'b0110; c1 = 0;
        aq.delete(); dq.delete();
        for (int i = 0; i < 600 && aq.size() < 5; i++) begin
            step();
            if (ack[1]) begin
                c1++;
                if (c1 == 3) req[1] = 1'b0;
                else begin
                    data[15:8] = 8'h10 + 8'(c1);
                    last[1]    = (c1 == 2);
                end
            end
        end
        req = 4'b0000;
`ifdef UARTARB_LOCK_EN
        exp_idx = '{1, 1, 1, 2, 2};
        exp_din = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h20};
`else
        exp_idx = '{1, 2, 1, 2, 1};
        exp_din = '{8'h10, 8'h20, 8'h11, 8'h20, 8'h12};
`endif
        check_val("pkt_count", {31'b0, aq.size() >= 5}, 32'd1);
        for (int i = 0; i < 5 && i < aq.size(); i++) begin
            check_val($sformatf("pkt_idx%0d", i), aq[i], exp_idx[i]);
            check_val($sformatf("pkt_din%0d", i), {24'b0, dq[i]}, {24'b0, exp_din[i]});
        end
        for (int i = 0; i < 30; i++) step();

        // Owner pauses mid-packet while requester 3 waits.
        tx_auto = 1'b0; tx_man = 1'b1;
        do_reset();
        data = 32'h3F000030; last = 4'b0000; req = 4'b0001;
        wait_ack(20, a, cyc);
        check_val("pause_first", {28'b0, a}, 32'h1);
        req = 4'b1000; last = 4'b1000; cnt = 0; c1 = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt += int'(tx_oe);
            c1  += int'(ack[3]);
        end
`ifdef UARTARB_LOCK_EN
        check_val("pause_no_oe", cnt, 32'd0);
`else
        check_val("pause_ack3", c1, 32'd10);
`endif
        req = 4'b1001; last = 4'b1001; data[7:0] = 8'h31;
        wait_ack(20, a, cyc);
        check_val("resume_ack", {28'b0, a}, 32'h1);
        check_val("resume_din", {24'b0, tx_din}, 32'h31);
        req = 4'b1000;
        wait_ack(20, a, cyc);
        check_val("after_ack", {28'b0, a}, 32'h8);
        check_val("after_din", {24'b0, tx_din}, 32'h3F);
        req = 4'b0000;
        for (int i = 0; i < 5; i++) step();

        // Reset while busy with the transmitter not ready.
        do_reset();
        data = 32'h00770000; last = 4'b0100; req = 4'b0100; tx_man = 1'b1;
        wait_ack(20, a, cyc);
        check_val("mid_first", {28'b0, a}, 32'h4);
        tx_man = 1'b0;
        step();
        nrst = 1'b0;
        step();
        check_val("mid_oe",  {31'b0, tx_oe}, 32'd0);
        check_val("mid_ack", {28'b0, ack},   32'd0);
        check_val("mid_gnt", {28'b0, gnt},   32'd0);
        check_val("mid_din", {24'b0, tx_din}, 32'd0);
        nrst = 1'b1; cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            cnt += int'(tx_oe);
        end
        check_val("mid_no_oe", cnt, 32'd0);
        tx_man = 1'b1;
        wait_ack(20, a, cyc);
        check_val("mid_resume_ack", {28'b0, a}, 32'h4);
        check_val("mid_resume_lat", cyc, 32'd1);
        check_val("mid_resume_din", {24'b0, tx_din}, 32'h77);
        check_val("mid_resume_gnt", {28'b0, gnt}, 32'h4);
        req = 4'b0000;
        for (int i = 0; i < 5; i++) step();

        check_val("protocol_viol", viol, 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
